// File: rtl/core_pkg.sv
// Shared core definitions: datapath width, ALU and branch op codes, IO window defaults.
package core_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned ALU_OP_W = 4;
  localparam int unsigned BR_OP_W  = 3;

  // ALU operation codes
  localparam logic [ALU_OP_W-1:0] ALU_ADD    = 4'b0000;
  localparam logic [ALU_OP_W-1:0] ALU_SUB    = 4'b0001;
  localparam logic [ALU_OP_W-1:0] ALU_SLL    = 4'b0010;
  localparam logic [ALU_OP_W-1:0] ALU_SLT    = 4'b0011;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU   = 4'b0100;
  localparam logic [ALU_OP_W-1:0] ALU_XOR    = 4'b0101;
  localparam logic [ALU_OP_W-1:0] ALU_SRL    = 4'b0110;
  localparam logic [ALU_OP_W-1:0] ALU_SRA    = 4'b0111;
  localparam logic [ALU_OP_W-1:0] ALU_OR     = 4'b1000;
  localparam logic [ALU_OP_W-1:0] ALU_AND    = 4'b1001;
  localparam logic [ALU_OP_W-1:0] ALU_PASS_B = 4'b1010;

  // Branch condition codes (rs1 compared against rs2)
  localparam logic [BR_OP_W-1:0] BR_EQ     = 3'b000;
  localparam logic [BR_OP_W-1:0] BR_NE     = 3'b001;
  localparam logic [BR_OP_W-1:0] BR_ALWAYS = 3'b010;
  localparam logic [BR_OP_W-1:0] BR_NEVER  = 3'b011;
  localparam logic [BR_OP_W-1:0] BR_LT     = 3'b100;
  localparam logic [BR_OP_W-1:0] BR_GE     = 3'b101;
  localparam logic [BR_OP_W-1:0] BR_LTU    = 3'b110;
  localparam logic [BR_OP_W-1:0] BR_GEU    = 3'b111;

  // Default memory-mapped IO window
  localparam logic [XLEN-1:0] IO_BASE_DEFAULT = 32'hFFFF_0000;
  localparam logic [XLEN-1:0] IO_MASK_DEFAULT = 32'hFFFF_0000;

endpackage

// File: rtl/exec_alu.sv
// Combinational ALU with zero flag.
// Ports: a, b operands; op ALU operation; result_c result; zero_c (result == 0).
module exec_alu
  import core_pkg::*;
#(
  parameter int unsigned XLEN_P = XLEN
) (
  input  logic [XLEN_P-1:0]   a,
  input  logic [XLEN_P-1:0]   b,
  input  logic [ALU_OP_W-1:0] op,
  output logic [XLEN_P-1:0]   result_c,
  output logic                zero_c
);

  localparam int unsigned SHAMT_W = $clog2(XLEN_P);

  logic [SHAMT_W-1:0] shamt;
  logic               lt_s;
  logic               lt_u;

  assign shamt = b[SHAMT_W-1:0];
  assign lt_s  = $signed(a) < $signed(b);
  assign lt_u  = a < b;

  // Operation select; unused codes yield zero
  always_comb begin
    result_c = '0;
    unique case (op)
      ALU_ADD:    result_c = a + b;
      ALU_SUB:    result_c = a - b;
      ALU_SLL:    result_c = a << shamt;
      ALU_SLT:    result_c = XLEN_P'(lt_s);
      ALU_SLTU:   result_c = XLEN_P'(lt_u);
      ALU_XOR:    result_c = a ^ b;
      ALU_SRL:    result_c = a >> shamt;
      ALU_SRA:    result_c = XLEN_P'($signed(a) >>> shamt);
      ALU_OR:     result_c = a | b;
      ALU_AND:    result_c = a & b;
      ALU_PASS_B: result_c = b;
      default:    result_c = '0;
    endcase
  end

  assign zero_c = (result_c == '0);

endmodule

// File: rtl/exec_unit.sv
// Execute stage: operand select, ALU, branch compare, next PC and RAM/IO address decode,
// all registered with one cycle of latency.
// Inputs:  clk, reset (async, active-high), in_valid, pc, rs1_value, rs2_value, ext_imm,
//          alu_a_src, alu_b_src, alu_op, branch_op, data_read_en, data_write_en.
// Outputs: out_valid, alu_out, zero, branch_taken, pc_next, mem_* (RAM port),
//          io_* (IO port), is_io (writeback read-data select).
module exec_unit
  import core_pkg::*;
#(
  parameter int unsigned     XLEN_P  = XLEN,
  parameter logic [XLEN_P-1:0] IO_BASE = IO_BASE_DEFAULT,
  parameter logic [XLEN_P-1:0] IO_MASK = IO_MASK_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [XLEN_P-1:0]   pc,
  input  logic [XLEN_P-1:0]   rs1_value,
  input  logic [XLEN_P-1:0]   rs2_value,
  input  logic [XLEN_P-1:0]   ext_imm,
  input  logic                alu_a_src,
  input  logic                alu_b_src,
  input  logic [ALU_OP_W-1:0] alu_op,
  input  logic [BR_OP_W-1:0]  branch_op,
  input  logic                data_read_en,
  input  logic                data_write_en,
  output logic                out_valid,
  output logic [XLEN_P-1:0]   alu_out,
  output logic                zero,
  output logic                branch_taken,
  output logic [XLEN_P-1:0]   pc_next,
  output logic [XLEN_P-1:0]   mem_address,
  output logic                mem_read_en,
  output logic                mem_write_en,
  output logic [XLEN_P-1:0]   mem_write_value,
  output logic [XLEN_P-1:0]   io_address,
  output logic                io_read_en,
  output logic                io_write_en,
  output logic [XLEN_P-1:0]   io_write_value,
  output logic                is_io
);

  localparam logic [XLEN_P-1:0] PC_STEP = XLEN_P'(4);

  logic [XLEN_P-1:0] op_a;
  logic [XLEN_P-1:0] op_b;
  logic [XLEN_P-1:0] alu_result;
  logic              alu_zero;
  logic              taken_c;
  logic [XLEN_P-1:0] pc_next_c;
  logic              io_hit_c;

  // Operand select
  assign op_a = alu_a_src ? pc      : rs1_value;
  assign op_b = alu_b_src ? ext_imm : rs2_value;

  exec_alu #(
    .XLEN_P (XLEN_P)
  ) u_alu (
    .a        (op_a),
    .b        (op_b),
    .op       (alu_op),
    .result_c (alu_result),
    .zero_c   (alu_zero)
  );

  // Branch decision compares register values, never the ALU operands
  always_comb begin
    taken_c = 1'b0;
    unique case (branch_op)
      BR_EQ:     taken_c = (rs1_value == rs2_value);
      BR_NE:     taken_c = (rs1_value != rs2_value);
      BR_ALWAYS: taken_c = 1'b1;
      BR_NEVER:  taken_c = 1'b0;
      BR_LT:     taken_c = ($signed(rs1_value) <  $signed(rs2_value));
      BR_GE:     taken_c = ($signed(rs1_value) >= $signed(rs2_value));
      BR_LTU:    taken_c = (rs1_value <  rs2_value);
      BR_GEU:    taken_c = (rs1_value >= rs2_value);
      default:   taken_c = 1'b0;
    endcase
  end

  assign pc_next_c = taken_c ? (pc + ext_imm) : (pc + PC_STEP);

  // IO window hit on the ALU-computed address
  assign io_hit_c = ((alu_result & IO_MASK) == (IO_BASE & IO_MASK));

  // Output register; strobes are gated by in_valid, data fields load unconditionally
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid       <= 1'b0;
      alu_out         <= '0;
      zero            <= 1'b0;
      branch_taken    <= 1'b0;
      pc_next         <= '0;
      mem_address     <= '0;
      mem_read_en     <= 1'b0;
      mem_write_en    <= 1'b0;
      mem_write_value <= '0;
      io_address      <= '0;
      io_read_en      <= 1'b0;
      io_write_en     <= 1'b0;
      io_write_value  <= '0;
      is_io           <= 1'b0;
    end else begin
      out_valid       <= in_valid;
      alu_out         <= alu_result;
      zero            <= alu_zero;
      branch_taken    <= in_valid & taken_c;
      pc_next         <= pc_next_c;
      mem_address     <= alu_result;
      mem_read_en     <= in_valid & data_read_en  & ~io_hit_c;
      mem_write_en    <= in_valid & data_write_en & ~io_hit_c;
      mem_write_value <= rs2_value;
      io_address      <= alu_result;
      io_read_en      <= in_valid & data_read_en  & io_hit_c;
      io_write_en     <= in_valid & data_write_en & io_hit_c;
      io_write_value  <= rs2_value;
      is_io           <= io_hit_c;
    end
  end

endmodule

// File: tb/tb_exec_unit.sv
// Randomized and directed bench for exec_unit against a behavioural reference model.
module tb_exec_unit;

  typedef struct {
    logic        v;
    logic [31:0] pc, rs1, rs2, imm;
    logic        asrc, bsrc;
    logic [3:0]  op;
    logic [2:0]  br;
    logic        rd, wr;
  } txn_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] pc = '0, rs1_value = '0, rs2_value = '0, ext_imm = '0;
  logic        alu_a_src = 1'b0, alu_b_src = 1'b0;
  logic [3:0]  alu_op = '0;
  logic [2:0]  branch_op = '0;
  logic        data_read_en = 1'b0, data_write_en = 1'b0;

  logic        out_valid, zero, branch_taken;
  logic [31:0] alu_out, pc_next, mem_address, mem_write_value, io_address, io_write_value;
  logic        mem_read_en, mem_write_en, io_read_en, io_write_en, is_io;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  exec_unit dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .pc              (pc),
    .rs1_value       (rs1_value),
    .rs2_value       (rs2_value),
    .ext_imm         (ext_imm),
    .alu_a_src       (alu_a_src),
    .alu_b_src       (alu_b_src),
    .alu_op          (alu_op),
    .branch_op       (branch_op),
    .data_read_en    (data_read_en),
    .data_write_en   (data_write_en),
    .out_valid       (out_valid),
    .alu_out         (alu_out),
    .zero            (zero),
    .branch_taken    (branch_taken),
    .pc_next         (pc_next),
    .mem_address     (mem_address),
    .mem_read_en     (mem_read_en),
    .mem_write_en    (mem_write_en),
    .mem_write_value (mem_write_value),
    .io_address      (io_address),
    .io_read_en      (io_read_en),
    .io_write_en     (io_write_en),
    .io_write_value  (io_write_value),
    .is_io           (is_io)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference ALU from the operation definitions
  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
    int          sa, sb;
    int unsigned sh;
    longint      wide;
    sa = int'(a);
    sb = int'(b);
    sh = int'(b) & 31;
    case (op)
      4'd0:  begin wide = longint'(a) + longint'(b); return wide[31:0]; end
      4'd1:  begin wide = longint'(a) - longint'(b); return wide[31:0]; end
      4'd2:  return a << sh;
      4'd3:  return (sa < sb) ? 32'd1 : 32'd0;
      4'd4:  return (a < b) ? 32'd1 : 32'd0;
      4'd5:  return a ^ b;
      4'd6:  return a >> sh;
      4'd7:  return 32'(sa >>> sh);
      4'd8:  return a | b;
      4'd9:  return a & b;
      4'd10: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_taken(input logic [31:0] x, input logic [31:0] y, input logic [2:0] br);
    int sx, sy;
    sx = int'(x);
    sy = int'(y);
    case (br)
      3'd0: return x == y;
      3'd1: return x != y;
      3'd2: return 1'b1;
      3'd3: return 1'b0;
      3'd4: return sx < sy;
      3'd5: return sx >= sy;
      3'd6: return x < y;
      default: return x >= y;
    endcase
  endfunction

  task automatic check_result(input txn_t t);
    logic [31:0] a, b, res, pcn;
    logic        tk, io;
    longint      sum;
    a   = t.asrc ? t.pc : t.rs1;
    b   = t.bsrc ? t.imm : t.rs2;
    res = ref_alu(a, b, t.op);
    tk  = ref_taken(t.rs1, t.rs2, t.br);
    sum = longint'(t.pc) + (tk ? longint'(t.imm) : 64'd4);
    pcn = sum[31:0];
    io  = (res[31:16] == 16'hFFFF);
    check_val("out_valid",    32'(out_valid),    32'(t.v));
    check_val("branch_taken", 32'(branch_taken), 32'(t.v & tk));
    check_val("mem_read_en",  32'(mem_read_en),  32'(t.v & t.rd & !io));
    check_val("mem_write_en", 32'(mem_write_en), 32'(t.v & t.wr & !io));
    check_val("io_read_en",   32'(io_read_en),   32'(t.v & t.rd & io));
    check_val("io_write_en",  32'(io_write_en),  32'(t.v & t.wr & io));
    if (t.v) begin
      check_val("alu_out",         alu_out,         res);
      check_val("zero",            32'(zero),       32'(res == 32'd0));
      check_val("pc_next",         pc_next,         pcn);
      check_val("mem_address",     mem_address,     res);
      check_val("io_address",      io_address,      res);
      check_val("mem_write_value", mem_write_value, t.rs2);
      check_val("io_write_value",  io_write_value,  t.rs2);
      check_val("is_io",           32'(is_io),      32'(io));
    end
  endtask

  task automatic check_all_zero(input string tag);
    logic [31:0] acc;
    acc = 32'(out_valid) | alu_out | 32'(zero) | 32'(branch_taken) | pc_next | mem_address |
          32'(mem_read_en) | 32'(mem_write_en) | mem_write_value | io_address |
          32'(io_read_en) | 32'(io_write_en) | io_write_value | 32'(is_io);
    check_val(tag, acc, 32'd0);
    check_val({tag, "_pc_next"}, pc_next, 32'd0);
  endtask

  task automatic drive(input txn_t t);
    in_valid = t.v; pc = t.pc; rs1_value = t.rs1; rs2_value = t.rs2; ext_imm = t.imm;
    alu_a_src = t.asrc; alu_b_src = t.bsrc; alu_op = t.op; branch_op = t.br;
    data_read_en = t.rd; data_write_en = t.wr;
  endtask

  task automatic run(input txn_t t);
    @(negedge clk);
    drive(t);
    @(posedge clk);
    #1;
    check_result(t);
  endtask

  function automatic txn_t base_txn();
    txn_t t;
    t.v = 1'b1; t.pc = 32'h100; t.rs1 = '0; t.rs2 = '0; t.imm = '0;
    t.asrc = 1'b0; t.bsrc = 1'b1; t.op = 4'd0; t.br = 3'd3; t.rd = 1'b0; t.wr = 1'b0;
    return t;
  endfunction

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return {16'hFFFF, 16'($urandom)};
      3: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    txn_t t;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset_init");
    reset = 1'b0;

    // ADD/SUB wrap
    t = base_txn(); t.rs1 = 32'hFFFF_FFFF; t.imm = 32'd1; t.op = 4'd0; run(t);
    check_val("add_wrap", alu_out, 32'd0);
    check_val("add_zero", 32'(zero), 32'd1);
    t = base_txn(); t.rs1 = 32'd0; t.imm = 32'd1; t.op = 4'd1; run(t);
    check_val("sub_wrap", alu_out, 32'hFFFF_FFFF);
    // Signed vs unsigned
    t = base_txn(); t.rs1 = 32'h8000_0000; t.imm = 32'd1; t.op = 4'd3; run(t);
    check_val("slt", alu_out, 32'd1);
    t.op = 4'd4; run(t);
    check_val("sltu", alu_out, 32'd0);
    t.op = 4'd7; t.imm = 32'd4; run(t);
    check_val("sra", alu_out, 32'hF800_0000);
    t.op = 4'd6; t.imm = 32'd36; run(t);
    check_val("srl", alu_out, 32'h0800_0000);
    // Branches
    t = base_txn(); t.imm = 32'h20; t.rs1 = 32'd5; t.rs2 = 32'd5; t.br = 3'd0; run(t);
    check_val("beq_pc", pc_next, 32'h120);
    t.rs1 = 32'hFFFF_FFFF; t.rs2 = 32'd1; t.br = 3'd4; run(t);
    check_val("blt_taken", 32'(branch_taken), 32'd1);
    t.br = 3'd6; run(t);
    check_val("bltu_pc", pc_next, 32'h104);
    t = base_txn(); t.imm = 32'hFFFF_FFF8; t.br = 3'd2; run(t);
    check_val("jal_pc", pc_next, 32'hF8);
    // Address decode
    t = base_txn(); t.rs1 = 32'h40; t.rs2 = 32'hCAFE; t.wr = 1'b1; run(t);
    check_val("st_mem_we", 32'(mem_write_en), 32'd1);
    check_val("st_is_io", 32'(is_io), 32'd0);
    t = base_txn(); t.rs1 = 32'hFFFF_0000; t.imm = 32'd4; t.rd = 1'b1; run(t);
    check_val("ld_io_re", 32'(io_read_en), 32'd1);
    check_val("ld_io_addr", io_address, 32'hFFFF_0004);
    // Valid gating
    t = base_txn(); t.v = 1'b0; t.rs1 = 32'd7; t.rs2 = 32'd7; t.br = 3'd0; t.wr = 1'b1; run(t);
    check_val("gate_taken", 32'(branch_taken), 32'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      t.v    = ($urandom_range(0, 9) != 0);
      t.pc   = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      t.rs1  = rand_word();
      t.rs2  = ($urandom_range(0, 3) == 0) ? t.rs1 : rand_word();
      t.imm  = rand_word();
      t.asrc = 1'($urandom);
      t.bsrc = 1'($urandom);
      t.op   = 4'($urandom);
      t.br   = 3'($urandom);
      t.rd   = 1'($urandom);
      t.wr   = 1'($urandom);
      run(t);
    end

    // Asynchronous reset between edges with nonzero outputs pending
    t = base_txn(); t.rs1 = 32'h1234; t.imm = 32'h10; t.br = 3'd2; t.rd = 1'b1; run(t);
    check_val("pre_reset_valid", 32'(out_valid), 32'd1);
    #1 reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    #1 reset = 1'b0;
    t = base_txn(); t.rs1 = 32'hFFFF_0010; t.imm = 32'h8; t.wr = 1'b1; t.rs2 = 32'h55; t.br = 3'd1;
    t.rs1 = 32'hFFFF_0010; run(t);
    check_val("post_reset_io_we", 32'(io_write_en), 32'd1);
    check_val("post_reset_addr", io_address, 32'hFFFF_0018);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
